// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0 -- canonical RISC-V NOP placed in a flushed IF/ID slot
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  // Text-segment base
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] PC_INCREMENT     = 32'd4;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: valid, PC, PC+4 and instruction with load/hold/flush.
// Latency: 1 clk from Load_i to outputs.
// Backpressure: holds contents when neither Load_i nor Flush_i is asserted; flush wins over load.
module if_id_register
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Load_i,
  input  logic                  Flush_i,
  input  logic [DATA_WIDTH-1:0] Pc_i,
  input  logic [DATA_WIDTH-1:0] Pc_Plus4_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Pc_o,
  output logic [DATA_WIDTH-1:0] Pc_Plus4_o,
  output logic [DATA_WIDTH-1:0] Instruction_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;

  // Select next contents: flush to an empty NOP slot, load a new fetch, or hold
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (Flush_i) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      pc_plus4_d = '0;
      instr_d    = DATA_WIDTH'(NOP_INSTR);
    end else if (Load_i) begin
      valid_d    = 1'b1;
      pc_d       = Pc_i;
      pc_plus4_d = Pc_Plus4_i;
      instr_d    = Instruction_i;
    end
  end

  // Register stage; synchronous reset empties the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign Valid_o       = valid_q;
  assign Pc_o          = pc_q;
  assign Pc_Plus4_o    = pc_plus4_q;
  assign Instruction_o = instr_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, next-PC select, BOOT/RUN/FAULT control and IF/ID capture.
// Latency: 1 clk from Pc_Address_o to IfId_* (program memory read is combinational).
// Backpressure: Stall_i holds PC, IF/ID and count; Redirect_i overrides Stall_i and flushes.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Enable_i,
  input  logic                   Stall_i,
  input  logic                   Redirect_i,
  input  logic [DATA_WIDTH-1:0]  Redirect_Target_i,
  input  logic [DATA_WIDTH-1:0]  Instruction_i,
  output logic [DATA_WIDTH-1:0]  Pc_Address_o,
  output logic                   IfId_Valid_o,
  output logic [DATA_WIDTH-1:0]  IfId_Pc_o,
  output logic [DATA_WIDTH-1:0]  IfId_Pc_Plus4_o,
  output logic [DATA_WIDTH-1:0]  IfId_Instruction_o,
  output logic                   Fault_o,
  output logic [DATA_WIDTH-1:0]  Fault_Address_o,
  output logic [COUNT_WIDTH-1:0] Fetch_Count_o
);

  fetch_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic [DATA_WIDTH-1:0]  fault_addr_q, fault_addr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0]  pc_plus4;
  logic                   target_misaligned;
  logic                   ifid_load;
  logic                   ifid_flush;

  // Sequential PC wraps naturally modulo 2^DATA_WIDTH
  assign pc_plus4          = pc_q + DATA_WIDTH'(PC_INCREMENT);
  assign target_misaligned = |Redirect_Target_i[1:0];

  // State and datapath registers; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      fault_addr_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  // Next-state: BOOT waits for enable, a misaligned redirect traps in FAULT until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  if (Enable_i) state_d = ST_RUN;
      ST_RUN:   if (Redirect_i && target_misaligned) state_d = ST_FAULT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Per-state controls: redirect beats stall beats sequential fetch
  always_comb begin
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (Redirect_i) begin
          ifid_flush = 1'b1;
          if (target_misaligned) begin
            fault_addr_d = Redirect_Target_i;
          end else begin
            pc_d = Redirect_Target_i;
          end
        end else if (!Stall_i) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          count_d   = count_q + COUNT_WIDTH'(1);
        end
      end
      // Keep the slot empty while trapped
      ST_FAULT: ifid_flush = 1'b1;
      default: ;
    endcase
  end

  if_id_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_if_id (
    .clk           (clk),
    .reset         (reset),
    .Load_i        (ifid_load),
    .Flush_i       (ifid_flush),
    .Pc_i          (pc_q),
    .Pc_Plus4_i    (pc_plus4),
    .Instruction_i (Instruction_i),
    .Valid_o       (IfId_Valid_o),
    .Pc_o          (IfId_Pc_o),
    .Pc_Plus4_o    (IfId_Pc_Plus4_o),
    .Instruction_o (IfId_Instruction_o)
  );

  assign Pc_Address_o    = pc_q;
  assign Fault_o         = (state_q == ST_FAULT);
  assign Fault_Address_o = fault_addr_q;
  assign Fetch_Count_o   = count_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that feeds Program_Memory in the RISC-V core. It holds the program counter, drives the instruction-memory address, and registers the returned combinational instruction into an IF/ID pipeline register with a valid bit. It supports stall, branch/jump redirect with flush, misaligned-target fault detection, and a delivered-instruction counter.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (text-segment base).
DATA_WIDTH, 32, width of PC, address and instruction.
COUNT_WIDTH, 32, width of Fetch_Count_o.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Enable_i  input  1  leaves BOOT when 1; ignored in other states
Stall_i  input  1  hold PC and IF/ID contents
Redirect_i  input  1  branch/jump taken this cycle
Redirect_Target_i  input  DATA_WIDTH  new PC when Redirect_i=1
Instruction_i  input  DATA_WIDTH  combinational read data from program memory
Pc_Address_o  output  DATA_WIDTH  address to program memory; equals pc_q
IfId_Valid_o  output  1  IF/ID register holds a real instruction
IfId_Pc_o  output  DATA_WIDTH  PC of registered instruction
IfId_Pc_Plus4_o  output  DATA_WIDTH  PC+4 of registered instruction
IfId_Instruction_o  output  DATA_WIDTH  registered instruction
Fault_o  output  1  level, high while in FAULT
Fault_Address_o  output  DATA_WIDTH  offending misaligned target
Fetch_Count_o  output  COUNT_WIDTH  count of instructions captured into IF/ID

Behaviour:
- Reset (sync, wins over everything): pc_q=RESET_PC, state=BOOT, IfId_Valid_o=0, IfId_Pc_o=0, IfId_Pc_Plus4_o=0, IfId_Instruction_o=32'h0000_0013 (NOP), Fault_o=0, Fault_Address_o=0, Fetch_Count_o=0. Reset mid-operation discards all in-flight state at that edge.
- Pc_Address_o = pc_q combinationally. Instruction_i is sampled in the same cycle. Capture latency is 1 clk.
- States: BOOT, RUN, FAULT.
- BOOT: no capture, pc_q held, valid=0. Enable_i=1 moves to RUN at the next edge. The first capture happens in the first RUN cycle.
- RUN, priority per edge: Redirect_i, then Stall_i, then normal.
  - Redirect_i=1 and Redirect_Target_i[1:0]==0: pc_q<=target. IF/ID flushed (valid<=0, instruction<=NOP, Pc/Pc_Plus4<=0). Count unchanged. Redirect overrides a simultaneous Stall_i.
  - Redirect_i=1 and target[1:0]!=0: state<=FAULT, Fault_Address_o<=target, pc_q held, IF/ID flushed, count unchanged.
  - Stall_i=1 with no redirect: pc_q, all IfId_* and count held. IfId_Valid_o is preserved, not cleared.
  - Normal: IfId_Pc_o<=pc_q, IfId_Pc_Plus4_o<=pc_q+4, IfId_Instruction_o<=Instruction_i, valid<=1, pc_q<=pc_q+4, count<=count+1.
- FAULT: Fault_o=1, valid=0, pc_q frozen; all inputs ignored. Only reset exits.
- Arithmetic: PC+4 is mod 2^DATA_WIDTH (32'hFFFF_FFFC wraps to 0). Fetch_Count_o is mod 2^COUNT_WIDTH.
- No alignment check on sequential PC; RESET_PC must be word aligned.

Decomposition:
- Package fetch_pkg: state encoding (BOOT/RUN/FAULT), NOP_INSTR=32'h0000_0013, default RESET_PC, PC_INCREMENT=4.
- One sub-module: if_id_register. It holds the valid/Pc/Pc_Plus4/Instruction fields with load, hold and flush controls.
- PC register, next-PC selection and FSM stay in instruction_fetch_unit.

Test Plan:
1. Reset, then Enable_i=1 with ROM word0=32'h0050_0093 -> Pc_Address_o=32'h0040_0000 in BOOT. One cycle after RUN entry: IfId_Pc_o=32'h0040_0000, IfId_Instruction_o=32'h0050_0093, valid=1, count=1, Pc_Address_o=32'h0040_0004.
2. Stall_i=1 for 3 cycles at pc 32'h0040_0008 -> PC, IfId_* and count unchanged, valid stays 1. Resumes with 32'h0040_0008 captured.
3. Redirect_i=1, target=32'h0040_0020, Stall_i=1 in the same cycle -> next cycle: Pc_Address_o=32'h0040_0020, valid=0, IfId_Instruction_o=NOP, count unchanged. The following cycle captures IfId_Pc_o=32'h0040_0020.
4. Redirect_i=1, target=32'h0040_0022 -> Fault_o=1, Fault_Address_o=32'h0040_0022, valid=0, PC frozen for 10 cycles despite stimulus. Reset clears Fault_o.
5. RESET_PC=32'hFFFF_FFF8, run 3 cycles -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; IfId_Pc_Plus4_o=0 for the FFFF_FFFC capture.
6. Reset asserted mid-RUN with count=7 and valid=1 -> next edge: state BOOT, count=0, valid=0, Pc_Address_o=RESET_PC.
